// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the fetch stage and hazard unit.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    // Redirect targets are word addresses; the two low bits carry no meaning.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard-unit controls, ID redirect targets, imem port and IF/ID outputs.
interface fetch_stage_if #(
    parameter int unsigned CNT_W = 16
) ();
    import mips_pkg::*;

    logic               pc_write;
    logic               IF_ID_write;
    logic               flush;
    logic [1:0]         pc_source;
    logic [31:0]        branch_target;
    logic [31:0]        jump_target;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;
    logic [31:0]        imem_addr;
    logic [31:0]        pc_plus4;
    logic [INSTR_W-1:0] if_id_instr;
    logic [31:0]        if_id_pc_plus4;
    logic               if_id_valid;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        input  pc_write, IF_ID_write, flush, pc_source, branch_target, jump_target,
               imem_rdata, imem_ready,
        output imem_addr, pc_plus4, if_id_instr, if_id_pc_plus4, if_id_valid,
               stall_cnt, flush_cnt
    );

    modport slave (
        output pc_write, IF_ID_write, flush, pc_source, branch_target, jump_target,
               imem_rdata, imem_ready,
        input  imem_addr, pc_plus4, if_id_instr, if_id_pc_plus4, if_id_valid,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats memory-wait bubble, else load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               write_en,
    input  logic               fetch_ready,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [31:0]        fetch_pc_plus4,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc_plus4,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc_plus4_q, pc_plus4_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!write_en) begin
            instr_d    = instr_q;
        end else if (!fetch_ready) begin
            // Bubble keeps the PC+4 so ID still sees a sensible link value.
            instr_d    = NOP_INSTR;
            pc_plus4_d = fetch_pc_plus4;
            valid_d    = 1'b0;
        end else begin
            instr_d    = fetch_instr;
            pc_plus4_d = fetch_pc_plus4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register, perf counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input logic            clk,
    input logic            rst,
    fetch_stage_if.master  bus
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_inc;
    logic [31:0]      target;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             stall_event;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        target = pc_inc;
        case (bus.pc_source)
            PC_BRANCH: target = word_align(bus.branch_target);
            PC_JUMP:   target = word_align(bus.jump_target);
            default:   target = pc_inc;
        endcase
    end

    // A redirect is taken even during a memory wait, abandoning that fetch.
    always_comb begin
        pc_d = pc_q;
        if (!bus.pc_write) begin
            pc_d = pc_q;
        end else if (bus.pc_source != PC_SEQ) begin
            pc_d = target;
        end else if (!bus.imem_ready) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_inc;
        end
    end

    assign stall_event = (!bus.pc_write || !bus.imem_ready) && !bus.flush;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_event && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (bus.flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk            (clk),
        .rst            (rst),
        .flush          (bus.flush),
        .write_en       (bus.IF_ID_write),
        .fetch_ready    (bus.imem_ready),
        .fetch_instr    (bus.imem_rdata),
        .fetch_pc_plus4 (pc_inc),
        .instr          (bus.if_id_instr),
        .pc_plus4       (bus.if_id_pc_plus4),
        .valid          (bus.if_id_valid)
    );

    assign bus.imem_addr = pc_q;
    assign bus.pc_plus4  = pc_inc;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns address XOR a fixed pattern.
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_stage_if #(.CNT_W(4)) bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst               = 1'b0;
        bus.pc_write      = 1'b1;
        bus.IF_ID_write   = 1'b1;
        bus.flush         = 1'b0;
        bus.pc_source     = 2'b00;
        bus.branch_target = 32'h0;
        bus.jump_target   = 32'h0;
        bus.imem_ready    = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        bus.pc_source = 2'b01;
        bus.branch_target = 32'h80;
        step();
        rst = 1'b0;
        bus.pc_source = 2'b00;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++;
            $display("FAIL reset_pc: got %h expected %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.pc_plus4 !== 32'h4) begin errors++;
            $display("FAIL reset_pc_plus4: got %h expected %h", bus.pc_plus4, 32'h4); end
        checks++; if (bus.if_id_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0", bus.if_id_valid); end
        checks++; if (bus.if_id_instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr: got %h expected 0", bus.if_id_instr); end
        checks++; if (bus.if_id_pc_plus4 !== 32'h0) begin errors++;
            $display("FAIL reset_ifid_pc4: got %h expected 0", bus.if_id_pc_plus4); end
        checks++; if (bus.stall_cnt !== 4'h0 || bus.flush_cnt !== 4'h0) begin errors++;
            $display("FAIL reset_cnt: got %h/%h expected 0/0", bus.stall_cnt, bus.flush_cnt); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int i = 1; i <= 3; i++) begin
            step();
            a = 32'(i) * 32'd4;
            checks++; if (bus.imem_addr !== a) begin errors++;
                $display("FAIL seq_addr%0d: got %h expected %h", i, bus.imem_addr, a); end
            checks++; if (bus.if_id_pc_plus4 !== a) begin errors++;
                $display("FAIL seq_pc4_%0d: got %h expected %h", i, bus.if_id_pc_plus4, a); end
            checks++; if (bus.if_id_instr !== instr_of(a - 32'd4)) begin errors++;
                $display("FAIL seq_instr%0d: got %h expected %h", i, bus.if_id_instr,
                         instr_of(a - 32'd4)); end
            checks++; if (bus.if_id_valid !== 1'b1) begin errors++;
                $display("FAIL seq_valid%0d: got %b expected 1", i, bus.if_id_valid); end
        end
    endtask

    task automatic test_branch();
        step();
        checks++; if (bus.imem_addr !== 32'h10) begin errors++;
            $display("FAIL br_pre_addr: got %h expected %h", bus.imem_addr, 32'h10); end
        bus.pc_source = 2'b01;
        bus.branch_target = 32'h40;
        bus.flush = 1'b1;
        step();
        set_idle();
        checks++; if (bus.imem_addr !== 32'h40) begin errors++;
            $display("FAIL br_addr: got %h expected %h", bus.imem_addr, 32'h40); end
        checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin errors++;
            $display("FAIL br_squash: got %b/%h expected 0/0", bus.if_id_valid,
                     bus.if_id_instr); end
        checks++; if (bus.flush_cnt !== 4'd1) begin errors++;
            $display("FAIL br_flush_cnt: got %0d expected 1", bus.flush_cnt); end
        step();
        checks++; if (bus.imem_addr !== 32'h44) begin errors++;
            $display("FAIL br_next_addr: got %h expected %h", bus.imem_addr, 32'h44); end
        checks++; if (bus.if_id_instr !== instr_of(32'h40) || bus.if_id_valid !== 1'b1)
            begin errors++;
            $display("FAIL br_target_instr: got %h/%b expected %h/1", bus.if_id_instr,
                     bus.if_id_valid, instr_of(32'h40)); end
        checks++; if (bus.stall_cnt !== 4'd0) begin errors++;
            $display("FAIL br_stall_cnt: got %0d expected 0", bus.stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.pc_source = 2'b10;
        bus.jump_target = 32'h20;
        step();
        bus.pc_source = 2'b00;
        bus.pc_write = 1'b0;
        bus.IF_ID_write = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            checks++; if (bus.imem_addr !== 32'h20) begin errors++;
                $display("FAIL lu_addr%0d: got %h expected %h", i, bus.imem_addr, 32'h20); end
            checks++; if (bus.if_id_instr !== instr_of(32'h0) || bus.if_id_pc_plus4 !== 32'h4
                          || bus.if_id_valid !== 1'b1) begin errors++;
                $display("FAIL lu_hold%0d: got %h/%h/%b expected %h/4/1", i, bus.if_id_instr,
                         bus.if_id_pc_plus4, bus.if_id_valid, instr_of(32'h0)); end
            checks++; if (bus.stall_cnt !== 4'(i)) begin errors++;
                $display("FAIL lu_stall%0d: got %0d expected %0d", i, bus.stall_cnt, i); end
        end
        set_idle();
        step();
        checks++; if (bus.imem_addr !== 32'h24 || bus.if_id_instr !== instr_of(32'h20)
                      || bus.if_id_pc_plus4 !== 32'h24) begin errors++;
            $display("FAIL lu_resume: got %h/%h/%h expected 24/%h/24", bus.imem_addr,
                     bus.if_id_instr, bus.if_id_pc_plus4, instr_of(32'h20)); end
        step();
        checks++; if (bus.imem_addr !== 32'h28 || bus.if_id_instr !== instr_of(32'h24))
            begin errors++;
            $display("FAIL lu_resume2: got %h/%h expected 28/%h", bus.imem_addr,
                     bus.if_id_instr, instr_of(32'h24)); end
        checks++; if (bus.stall_cnt !== 4'd2) begin errors++;
            $display("FAIL lu_stall_final: got %0d expected 2", bus.stall_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        step();
        step();
        bus.imem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (bus.imem_addr !== 32'h8) begin errors++;
                $display("FAIL mw_addr%0d: got %h expected 8", i, bus.imem_addr); end
            checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0
                          || bus.if_id_pc_plus4 !== 32'hC) begin errors++;
                $display("FAIL mw_bubble%0d: got %b/%h/%h expected 0/0/c", i, bus.if_id_valid,
                         bus.if_id_instr, bus.if_id_pc_plus4); end
            checks++; if (bus.stall_cnt !== 4'(i)) begin errors++;
                $display("FAIL mw_stall%0d: got %0d expected %0d", i, bus.stall_cnt, i); end
        end
        bus.pc_source = 2'b10;
        bus.jump_target = 32'h103;
        step();
        checks++; if (bus.imem_addr !== 32'h100) begin errors++;
            $display("FAIL mw_jump_addr: got %h expected 100", bus.imem_addr); end
        checks++; if (bus.if_id_valid !== 1'b0 || bus.stall_cnt !== 4'd4) begin errors++;
            $display("FAIL mw_jump_bubble: got %b/%0d expected 0/4", bus.if_id_valid,
                     bus.stall_cnt); end
        set_idle();
        step();
        checks++; if (bus.imem_addr !== 32'h104 || bus.if_id_instr !== instr_of(32'h100)
                      || bus.if_id_pc_plus4 !== 32'h104 || bus.if_id_valid !== 1'b1)
            begin errors++;
            $display("FAIL mw_after_jump: got %h/%h/%h/%b expected 104/%h/104/1",
                     bus.imem_addr, bus.if_id_instr, bus.if_id_pc_plus4, bus.if_id_valid,
                     instr_of(32'h100)); end
    endtask

    task automatic test_wrap_priority();
        do_reset();
        bus.pc_source = 2'b10;
        bus.jump_target = 32'hFFFF_FFFC;
        step();
        bus.pc_source = 2'b00;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin errors++;
            $display("FAIL wrap_top: got %h/%h expected fffffffc/0", bus.imem_addr,
                     bus.pc_plus4); end
        step();
        checks++; if (bus.imem_addr !== 32'h0 || bus.if_id_pc_plus4 !== 32'h0
                      || bus.if_id_instr !== instr_of(32'hFFFF_FFFC)) begin errors++;
            $display("FAIL wrap_next: got %h/%h/%h expected 0/0/%h", bus.imem_addr,
                     bus.if_id_pc_plus4, bus.if_id_instr, instr_of(32'hFFFF_FFFC)); end
        bus.pc_source = 2'b11;
        step();
        bus.pc_source = 2'b00;
        checks++; if (bus.imem_addr !== 32'h4) begin errors++;
            $display("FAIL reserved_src: got %h expected 4", bus.imem_addr); end
        bus.IF_ID_write = 1'b0;
        step();
        checks++; if (bus.imem_addr !== 32'h8 || bus.if_id_instr !== instr_of(32'h0)
                      || bus.if_id_pc_plus4 !== 32'h4 || bus.if_id_valid !== 1'b1)
            begin errors++;
            $display("FAIL pcw_only: got %h/%h/%h/%b expected 8/%h/4/1", bus.imem_addr,
                     bus.if_id_instr, bus.if_id_pc_plus4, bus.if_id_valid,
                     instr_of(32'h0)); end
        bus.flush = 1'b1;
        step();
        set_idle();
        checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0
                      || bus.if_id_pc_plus4 !== 32'h0) begin errors++;
            $display("FAIL flush_beats_hold: got %b/%h/%h expected 0/0/0", bus.if_id_valid,
                     bus.if_id_instr, bus.if_id_pc_plus4); end
        checks++; if (bus.flush_cnt !== 4'd1) begin errors++;
            $display("FAIL wrap_flush_cnt: got %0d expected 1", bus.flush_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.pc_write = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                checks++; if (bus.stall_cnt !== 4'hE) begin errors++;
                    $display("FAIL sat_stall14: got %h expected e", bus.stall_cnt); end
            end
            if (i == 15 || i == 20) begin
                checks++; if (bus.stall_cnt !== 4'hF) begin errors++;
                    $display("FAIL sat_stall%0d: got %h expected f", i, bus.stall_cnt); end
            end
        end
        rst = 1'b1;
        bus.pc_source = 2'b01;
        bus.branch_target = 32'h80;
        bus.flush = 1'b1;
        step();
        set_idle();
        checks++; if (bus.imem_addr !== 32'h0 || bus.stall_cnt !== 4'h0
                      || bus.flush_cnt !== 4'h0 || bus.if_id_valid !== 1'b0) begin errors++;
            $display("FAIL mid_reset: got %h/%h/%h/%b expected 0/0/0/0", bus.imem_addr,
                     bus.stall_cnt, bus.flush_cnt, bus.if_id_valid); end
        bus.flush = 1'b1;
        for (int i = 1; i <= 18; i++) step();
        set_idle();
        checks++; if (bus.flush_cnt !== 4'hF || bus.stall_cnt !== 4'h0) begin errors++;
            $display("FAIL sat_flush: got %h/%h expected f/0", bus.flush_cnt,
                     bus.stall_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        set_idle();
        test_reset();
        test_sequential();
        test_branch();
        test_load_use();
        test_mem_wait();
        test_wrap_priority();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
